// File: rtl/fsm_bus_arbiter.sv
// ============================================================================
// Module      : fsm_bus_arbiter
// Description : Round-robin sharing of the flash/FSM tristate bus between two
//               requesters, sequenced through setup/strobe/hold/turnaround.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fsm_bus_arbiter #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16,
    parameter int SETUP  = 2,
    parameter int WAIT   = 8,
    parameter int HOLD   = 2,
    parameter int TURN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_req,
    input  logic              rq0_cs,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic              rq0_write,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ack,
    input  logic              rq1_req,
    input  logic              rq1_cs,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic              rq1_write,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] fsm_a,
    output logic [DATA_W-1:0] fsm_d_out,
    output logic              fsm_d_oe,
    input  logic [DATA_W-1:0] fsm_d_in,
    output logic [1:0]        fsm_cs_n,
    output logic              fsm_oen,
    output logic              fsm_wen
);

    localparam int CW = 16;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_access = 3'd2;
    localparam logic [2:0] c_st_hold   = 3'd3;
    localparam logic [2:0] c_st_turn   = 3'd4;

    localparam logic [CW-1:0] c_zero     = '0;
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_setup_ld = CW'(SETUP - 1);
    localparam logic [CW-1:0] c_wait_ld  = CW'(WAIT - 1);
    localparam logic [CW-1:0] c_hold_ld  = CW'(HOLD - 1);
    localparam logic [CW-1:0] c_turn_ld  = CW'(TURN - 1);

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_sel;
    logic              r_last;
    logic              r_write;

    logic              w_any;
    logic              w_win;
    logic              w_cs;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Under contention the requester not granted last wins; a sole requester always wins.
    always_comb begin
        w_any   = rq0_req | rq1_req;
        w_win   = (rq0_req & rq1_req) ? ~r_last : rq1_req;
        w_cs    = w_win ? rq1_cs    : rq0_cs;
        w_write = w_win ? rq1_write : rq0_write;
        w_addr  = w_win ? rq1_addr  : rq0_addr;
        w_wdata = w_win ? rq1_wdata : rq0_wdata;
    end

    assign busy = (r_state != c_st_idle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= c_zero;
            r_sel     <= 1'b0;
            r_last    <= 1'b1;
            r_write   <= 1'b0;
            rq0_ack   <= 1'b0;
            rq1_ack   <= 1'b0;
            rd_data   <= '0;
            fsm_a     <= '0;
            fsm_d_out <= '0;
            fsm_d_oe  <= 1'b0;
            fsm_cs_n  <= 2'b11;
            fsm_oen   <= 1'b1;
            fsm_wen   <= 1'b1;
        end else begin
            rq0_ack <= 1'b0;
            rq1_ack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_state   <= c_st_setup;
                        r_cnt     <= c_setup_ld;
                        r_sel     <= w_win;
                        r_last    <= w_win;
                        r_write   <= w_write;
                        fsm_a     <= w_addr;
                        fsm_d_out <= w_wdata;
                        fsm_d_oe  <= w_write;
                        fsm_cs_n  <= w_cs ? 2'b01 : 2'b10;
                    end
                end
                c_st_setup: begin
                    if (r_cnt == c_zero) begin
                        r_state <= c_st_access;
                        r_cnt   <= c_wait_ld;
                        fsm_oen <= r_write;
                        fsm_wen <= ~r_write;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                c_st_access: begin
                    if (r_cnt == c_zero) begin
                        if (!r_write) begin
                            rd_data <= fsm_d_in;
                        end
                        r_state <= c_st_hold;
                        r_cnt   <= c_hold_ld;
                        fsm_oen <= 1'b1;
                        fsm_wen <= 1'b1;
                        // A single-cycle hold is also the last hold cycle, so ack now.
                        if (HOLD == 1) begin
                            rq0_ack <= ~r_sel;
                            rq1_ack <= r_sel;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                c_st_hold: begin
                    if (r_cnt == c_zero) begin
                        fsm_cs_n <= 2'b11;
                        fsm_d_oe <= 1'b0;
                        if (TURN == 0) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_state <= c_st_turn;
                            r_cnt   <= c_turn_ld;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                        if (r_cnt == c_one) begin
                            rq0_ack <= ~r_sel;
                            rq1_ack <= r_sel;
                        end
                    end
                end
                c_st_turn: begin
                    if (r_cnt == c_zero) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fsm_bus_arbiter.sv
// ============================================================================
// Module      : tb_fsm_bus_arbiter
// Description : Self-checking bench for fsm_bus_arbiter (vector table + ack scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fsm_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;

    logic        rq0_req, rq0_cs, rq0_write, rq0_ack;
    logic [24:0] rq0_addr;
    logic [15:0] rq0_wdata;
    logic        rq1_req, rq1_cs, rq1_write, rq1_ack;
    logic [24:0] rq1_addr;
    logic [15:0] rq1_wdata;
    logic [15:0] rd_data, fsm_d_out, fsm_d_in;
    logic        busy, fsm_d_oe, fsm_oen, fsm_wen;
    logic [24:0] fsm_a;
    logic [1:0]  fsm_cs_n;

    logic        b_rq0_req, b_rq0_ack, b_rq1_ack;
    logic [15:0] b_rd_data, b_d_out, b_d_in;
    logic        b_busy, b_d_oe, b_oen, b_wen;
    logic [24:0] b_a;
    logic [1:0]  b_cs_n;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        b_d_in <= 16'h1000 + 16'(cyc + 1);
    end

    fsm_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .rq0_req(rq0_req), .rq0_cs(rq0_cs), .rq0_addr(rq0_addr), .rq0_write(rq0_write),
        .rq0_wdata(rq0_wdata), .rq0_ack(rq0_ack),
        .rq1_req(rq1_req), .rq1_cs(rq1_cs), .rq1_addr(rq1_addr), .rq1_write(rq1_write),
        .rq1_wdata(rq1_wdata), .rq1_ack(rq1_ack),
        .rd_data(rd_data), .busy(busy), .fsm_a(fsm_a), .fsm_d_out(fsm_d_out),
        .fsm_d_oe(fsm_d_oe), .fsm_d_in(fsm_d_in), .fsm_cs_n(fsm_cs_n),
        .fsm_oen(fsm_oen), .fsm_wen(fsm_wen)
    );

    fsm_bus_arbiter #(.SETUP(1), .WAIT(1), .HOLD(1), .TURN(0)) dut_fast (
        .clk(clk), .reset(reset),
        .rq0_req(b_rq0_req), .rq0_cs(1'b0), .rq0_addr(25'h5), .rq0_write(1'b0),
        .rq0_wdata(16'h0), .rq0_ack(b_rq0_ack),
        .rq1_req(1'b0), .rq1_cs(1'b0), .rq1_addr(25'h0), .rq1_write(1'b0),
        .rq1_wdata(16'h0), .rq1_ack(b_rq1_ack),
        .rd_data(b_rd_data), .busy(b_busy), .fsm_a(b_a), .fsm_d_out(b_d_out),
        .fsm_d_oe(b_d_oe), .fsm_d_in(b_d_in), .fsm_cs_n(b_cs_n),
        .fsm_oen(b_oen), .fsm_wen(b_wen)
    );

    typedef struct {
        bit          sel;
        bit          cs;
        logic [24:0] addr;
        bit          write;
        logic [15:0] wdata;
        logic [15:0] din;
        logic [1:0]  exp_cs_n;
        logic [15:0] exp_rd;
    } vec_t;

    typedef struct {
        bit          who;
        logic [15:0] rd;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit who, input int limit);
        int n = 0;
        while (!(who ? rq1_ack : rq0_ack) && n < limit) begin
            tick();
            n++;
        end
        tests++;
        if (n >= limit) begin
            failed++;
            $display("FAIL wait_ack%0d: no ack within %0d cycles", who, limit);
        end
    endtask

    task automatic drive(input vec_t v);
        fsm_d_in = v.din;
        if (v.sel) begin
            rq1_cs = v.cs; rq1_addr = v.addr; rq1_write = v.write; rq1_wdata = v.wdata; rq1_req = 1'b1;
        end else begin
            rq0_cs = v.cs; rq0_addr = v.addr; rq0_write = v.write; rq0_wdata = v.wdata; rq0_req = 1'b1;
        end
    endtask

    // Bus-safety invariants every cycle, plus in-order ack/read-data scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if (fsm_cs_n == 2'b00 || (!fsm_oen && !fsm_wen) || (fsm_d_oe && !fsm_oen)
                || (rq0_ack && rq1_ack)) begin
                failed++;
                $display("FAIL bus_invariant @cyc %0d: cs_n=%b oen=%b wen=%b d_oe=%b acks=%b%b",
                         cyc, fsm_cs_n, fsm_oen, fsm_wen, fsm_d_oe, rq1_ack, rq0_ack);
            end
            if (rq0_ack || rq1_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {30'b0, rq1_ack, rq0_ack}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_who", {31'b0, rq1_ack}, {31'b0, e.who});
                    chk("ack_rd_data", {16'b0, rd_data}, {16'b0, e.rd});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        vecs[0] = '{0, 0, 25'h0001234, 0, 16'h0000, 16'hBEEF, 2'b10, 16'hBEEF};
        vecs[1] = '{1, 1, 25'h1FFFFFF, 1, 16'hA5A5, 16'h0BAD, 2'b01, 16'hBEEF};
        vecs[2] = '{1, 1, 25'h0000000, 0, 16'h0000, 16'h0000, 2'b01, 16'h0000};
        vecs[3] = '{0, 0, 25'h0AAAAAA, 1, 16'h5A5A, 16'h1357, 2'b10, 16'h0000};
        vecs[4] = '{0, 1, 25'h1555555, 0, 16'h0000, 16'hFFFF, 2'b01, 16'hFFFF};
        vecs[5] = '{1, 0, 25'h0000001, 0, 16'h0000, 16'h1234, 2'b10, 16'h1234};

        rq0_req = 0; rq0_cs = 0; rq0_addr = '0; rq0_write = 0; rq0_wdata = '0;
        rq1_req = 0; rq1_cs = 0; rq1_addr = '0; rq1_write = 0; rq1_wdata = '0;
        fsm_d_in = '0; b_rq0_req = 0;

        repeat (2) tick();
        chk("rst_cs_n", {30'b0, fsm_cs_n}, 32'h3);
        chk("rst_strobes", {29'b0, fsm_oen, fsm_wen, fsm_d_oe}, 32'h6);
        chk("rst_a_dout", {7'b0, fsm_a}, {16'b0, fsm_d_out});
        chk("rst_rd_busy_ack", {13'b0, rd_data, busy, rq0_ack, rq1_ack}, 32'h0);
        chk("rst_fast_cs_busy", {29'b0, b_cs_n, b_busy}, 32'h6);
        reset = 1'b0;
        tick();

        // Single-requester accesses, checked phase by phase against the default timing.
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = vecs[i];
            drive(v);
            sb.push_back('{v.sel, v.exp_rd});
            chk("t0_busy", {31'b0, busy}, 32'h0);
            for (int off = 1; off <= 14; off++) begin
                bit in_acc, in_sel;
                tick();
                in_sel = (off >= 1 && off <= 12);
                in_acc = (off >= 3 && off <= 10);
                chk("cs_n", {30'b0, fsm_cs_n}, in_sel ? {30'b0, v.exp_cs_n} : 32'h3);
                chk("oen", {31'b0, fsm_oen}, (!v.write && in_acc) ? 32'h0 : 32'h1);
                chk("wen", {31'b0, fsm_wen}, (v.write && in_acc) ? 32'h0 : 32'h1);
                chk("d_oe", {31'b0, fsm_d_oe}, (v.write && in_sel) ? 32'h1 : 32'h0);
                chk("addr", {7'b0, fsm_a}, {7'b0, v.addr});
                if (v.write && in_sel) chk("d_out", {16'b0, fsm_d_out}, {16'b0, v.wdata});
                chk("ack", {31'b0, v.sel ? rq1_ack : rq0_ack}, (off == 12) ? 32'h1 : 32'h0);
                chk("busy", {31'b0, busy}, (off <= 13) ? 32'h1 : 32'h0);
                if (off == 12) begin
                    if (v.sel) rq1_req = 1'b0; else rq0_req = 1'b0;
                end
            end
        end

        // Contention: both held for four accesses, grants must alternate 0,1,0,1.
        rq0_cs = 0; rq0_addr = 25'h10; rq0_write = 0; rq0_wdata = '0;
        rq1_cs = 1; rq1_addr = 25'h20; rq1_write = 1; rq1_wdata = 16'h1111;
        fsm_d_in = 16'h7E57;
        for (int k = 0; k < 4; k++) sb.push_back('{k[0], 16'h7E57});
        rq0_req = 1; rq1_req = 1;
        for (int k = 0; k < 4; k++) begin
            for (int off = 1; off <= 14; off++) begin
                tick();
                if (off == 1) chk("rr_cs_n", {30'b0, fsm_cs_n}, k[0] ? 32'h1 : 32'h2);
                if (off == 12) chk("rr_ack", {30'b0, rq1_ack, rq0_ack}, k[0] ? 32'h2 : 32'h1);
                if (off == 13) chk("turn_gap", {29'b0, fsm_cs_n, fsm_d_oe}, 32'h6);
                if (k == 3 && off == 12) begin
                    rq0_req = 0; rq1_req = 0;
                end
            end
        end

        // Reset in the middle of a write strobe, then contention after release.
        rq0_cs = 0; rq0_addr = 25'h0ABCDE; rq0_write = 1; rq0_wdata = 16'hC3C3; rq0_req = 1;
        repeat (5) tick();
        chk("pre_rst_wen", {31'b0, fsm_wen}, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_bus", {28'b0, fsm_cs_n, fsm_wen, fsm_d_oe}, 32'hE);
        chk("mid_rst_state", {14'b0, rd_data, busy, rq0_ack, rq1_ack}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        rq1_cs = 1; rq1_addr = 25'h77; rq1_write = 0; fsm_d_in = 16'h4444; rq1_req = 1;
        sb.push_back('{0, 16'h0000});
        sb.push_back('{1, 16'h4444});
        tick();
        chk("post_rst_grant", {30'b0, fsm_cs_n}, 32'h2);
        wait_ack(0, 20);
        rq0_req = 0;
        tick();
        wait_ack(1, 20);
        rq1_req = 0;
        repeat (3) tick();
        chk("sb_empty", sb.size(), 32'h0);

        // Minimal timing, back-to-back reads: ack every 4 cycles with the sampled data.
        b_rq0_req = 1;
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            while (cyc < t0 + 4 * k + 2) tick();
            chk("fast_no_ack", {31'b0, b_rq0_ack}, 32'h0);
            tick();
            chk("fast_ack", {31'b0, b_rq0_ack}, 32'h1);
            chk("fast_rd", {16'b0, b_rd_data}, {16'b0, 16'h1000 + 16'(t0 + 4 * k + 2)});
            if (k == 3) b_rq0_req = 0;
        end
        repeat (3) tick();
        chk("fast_idle", {30'b0, b_busy, b_rq0_ack}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
